// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types, field lengths and status layout for the SPI register slave
package spi_reg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INSTR,
        ST_GAP,
        ST_ADDR,
        ST_WDATA,
        ST_DUMMY,
        ST_RDATA,
        ST_STATUS,
        ST_DONE,
        ST_SKIP
    } state_e;

    localparam logic [7:0] INSTR_WRITE = 8'h00;
    localparam logic [7:0] INSTR_READ  = 8'h01;

    localparam int INSTR_BITS  = 8;
    localparam int GAP_BITS    = 1;
    localparam int ADDR_BITS   = 32;
    localparam int DATA_BITS   = 32;
    localparam int DUMMY_BITS  = 8;
    localparam int STATUS_BITS = 8;

    localparam int STAT_OK      = 0;
    localparam int STAT_ERR     = 1;
    localparam int STAT_TIMEOUT = 2;

    // Number of sck bits a state consumes; zero means sck is ignored there.
    function automatic logic [5:0] field_len(state_e st);
        case (st)
            ST_INSTR:  return 6'(INSTR_BITS);
            ST_GAP:    return 6'(GAP_BITS);
            ST_ADDR:   return 6'(ADDR_BITS);
            ST_WDATA:  return 6'(DATA_BITS);
            ST_DUMMY:  return 6'(DUMMY_BITS);
            ST_RDATA:  return 6'(DATA_BITS);
            ST_STATUS: return 6'(STATUS_BITS);
            default:   return 6'd0;
        endcase
    endfunction

    function automatic logic [STATUS_BITS-1:0] status_byte(logic ok, logic err, logic timeout);
        logic [STATUS_BITS-1:0] s;
        s               = '0;
        s[STAT_OK]      = ok;
        s[STAT_ERR]     = err;
        s[STAT_TIMEOUT] = timeout;
        return s;
    endfunction

endpackage

// File: rtl/spi_reg_slave_if.sv
// rtl/spi_reg_slave_if.sv - single-beat internal register bus between SPI slave and register file
interface spi_reg_slave_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_err, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_err, bus_rdata
    );
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - synchronizers for the async SPI pins plus sck edge and ss_n fall detect
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic ss_n,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_n_s,
    output logic ss_fall,
    output logic mosi_s
);
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   ss_prev_q, ss_prev_d;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sck_prev_d  = sck_sync_q[SYNC_STAGES-1];
        ss_prev_d   = ss_sync_q[SYNC_STAGES-1];
    end

    // ss_n resets to deselected so a low pin at reset release is not taken as a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= sck_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            ss_prev_q   <= ss_prev_d;
        end
    end

    assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
    assign ss_n_s   = ss_sync_q[SYNC_STAGES-1];
    assign ss_fall  = ~ss_sync_q[SYNC_STAGES-1] & ss_prev_q;
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - SPI mode-0 slave turning 89-bit register frames into single-beat bus requests
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         BUS_TIMEOUT = 32,
    parameter logic [7:0] WRITE_INSTR = INSTR_WRITE,
    parameter logic [7:0] READ_INSTR  = INSTR_READ
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sck,
    input  logic            ss_n,
    input  logic            mosi,
    output logic            miso,
    spi_reg_slave_if.master bus
);
    localparam int TW = $clog2(BUS_TIMEOUT + 1);

    logic sck_rise, sck_fall, ss_n_s, ss_fall, mosi_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .sck      (sck),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ss_n_s   (ss_n_s),
        .ss_fall  (ss_fall),
        .mosi_s   (mosi_s)
    );

    state_e                 state_q, state_d;
    logic [5:0]             cnt_q, cnt_d, len;
    logic                   field_done;
    logic [DATA_BITS-1:0]   shift_q, shift_d, shift_in;
    logic                   is_read_q, is_read_d;
    logic [ADDR_BITS-1:0]   stage_addr_q, stage_addr_d;
    logic [DATA_BITS-1:0]   stage_wdata_q, stage_wdata_d;
    logic                   pend_q, pend_d;
    logic                   req_q, req_d, we_q, we_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   wdata_q, wdata_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   discard_q, discard_d;
    logic                   ok_q, ok_d, err_q, err_d, to_q, to_d;
    logic [DATA_BITS-1:0]   rdata_q, rdata_d, rd_word;
    logic [STATUS_BITS-1:0] status_w;
    logic                   miso_q, miso_d;

    assign len      = field_len(state_q);
    assign shift_in = {shift_q[DATA_BITS-2:0], mosi_s};
    assign rd_word  = ok_q ? rdata_q : '0;
    assign status_w = status_byte(ok_q, err_q, to_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        field_done = 1'b0;
        if (state_q == ST_IDLE) begin
            if (ss_fall) begin
                state_d = ST_INSTR;
                cnt_d   = '0;
            end
        end else if (ss_n_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (sck_rise && len != 6'd0) begin
            if (cnt_q == len - 6'd1) begin
                field_done = 1'b1;
                cnt_d      = '0;
                case (state_q)
                    ST_INSTR:  state_d = (shift_in[7:0] == WRITE_INSTR || shift_in[7:0] == READ_INSTR)
                                         ? ST_GAP : ST_SKIP;
                    ST_GAP:    state_d = ST_ADDR;
                    ST_ADDR:   state_d = is_read_q ? ST_DUMMY : ST_WDATA;
                    ST_WDATA:  state_d = ST_DUMMY;
                    ST_DUMMY:  state_d = is_read_q ? ST_RDATA : ST_STATUS;
                    ST_RDATA:  state_d = ST_STATUS;
                    ST_STATUS: state_d = ST_DONE;
                    default:   state_d = state_q;
                endcase
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    always_comb begin
        shift_d       = shift_q;
        is_read_d     = is_read_q;
        stage_addr_d  = stage_addr_q;
        stage_wdata_d = stage_wdata_q;
        pend_d        = pend_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        timer_d       = timer_q;
        discard_d     = discard_q;
        ok_d          = ok_q;
        err_d         = err_q;
        to_d          = to_q;
        rdata_d       = rdata_q;
        miso_d        = miso_q;

        if (sck_rise && len != 6'd0) shift_d = shift_in;

        if (state_q == ST_IDLE && ss_fall) begin
            ok_d    = 1'b0;
            err_d   = 1'b0;
            to_d    = 1'b0;
            rdata_d = '0;
        end

        // A queued request waits here until any older (possibly discarded) access has dropped.
        if (req_q) begin
            timer_d = timer_q + 1'b1;
            if (bus.bus_ack) begin
                req_d = 1'b0;
                if (!discard_q) begin
                    ok_d    = !bus.bus_err;
                    err_d   = bus.bus_err;
                    rdata_d = bus.bus_rdata;
                end
            end else if (timer_q == TW'(BUS_TIMEOUT - 1)) begin
                req_d = 1'b0;
                if (!discard_q) to_d = 1'b1;
            end
        end else if (pend_q) begin
            req_d     = 1'b1;
            we_d      = !is_read_q;
            addr_d    = stage_addr_q;
            wdata_d   = stage_wdata_q;
            timer_d   = '0;
            pend_d    = 1'b0;
            discard_d = 1'b0;
        end

        if (field_done) begin
            case (state_q)
                ST_INSTR: is_read_d = (shift_in[7:0] == READ_INSTR);
                ST_ADDR: begin
                    stage_addr_d = shift_in;
                    pend_d       = is_read_q;
                end
                ST_WDATA: begin
                    stage_wdata_d = shift_in;
                    pend_d        = 1'b1;
                end
                default: ;
            endcase
        end

        if (state_q != ST_IDLE && ss_n_s) begin
            pend_d = 1'b0;
            if (req_q) discard_d = 1'b1;
        end

        if (ss_n_s) begin
            miso_d = 1'b0;
        end else if (sck_fall) begin
            case (state_q)
                ST_RDATA:  miso_d = rd_word[5'd31 - cnt_q[4:0]];
                ST_STATUS: miso_d = status_w[3'd7 - cnt_q[2:0]];
                default:   miso_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q       <= '0;
            is_read_q     <= 1'b0;
            stage_addr_q  <= '0;
            stage_wdata_q <= '0;
            pend_q        <= 1'b0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            timer_q       <= '0;
            discard_q     <= 1'b0;
            ok_q          <= 1'b0;
            err_q         <= 1'b0;
            to_q          <= 1'b0;
            rdata_q       <= '0;
            miso_q        <= 1'b0;
        end else begin
            shift_q       <= shift_d;
            is_read_q     <= is_read_d;
            stage_addr_q  <= stage_addr_d;
            stage_wdata_q <= stage_wdata_d;
            pend_q        <= pend_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            timer_q       <= timer_d;
            discard_q     <= discard_d;
            ok_q          <= ok_d;
            err_q         <= err_d;
            to_q          <= to_d;
            rdata_q       <= rdata_d;
            miso_q        <= miso_d;
        end
    end

    assign miso          = miso_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb/tb_spi_reg_slave.sv - scoreboard bench for spi_reg_slave with SPI master, bus responder and monitors
module tb_spi_reg_slave;

    localparam int HALF = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0;
    logic ss_n = 1'b1;
    logic mosi = 1'b0;
    logic miso;

    spi_reg_slave_if bus_if ();

    spi_reg_slave #(
        .SYNC_STAGES (2),
        .BUS_TIMEOUT (32),
        .WRITE_INSTR (8'h00),
        .READ_INSTR  (8'h01)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sck   (sck),
        .ss_n  (ss_n),
        .mosi  (mosi),
        .miso  (miso),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        bit          noack;
        int          delay;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    bus_exp_t    exp_bus_q[$];
    resp_t       resp_q[$];
    logic [88:0] exp_frame_q[$];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic spi_send(input logic [88:0] tx, input int nbits);
        ss_n = 1'b0;
        mosi = tx[88];
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
            if (i < 88) mosi = tx[87-i];
            wait_clk(HALF);
        end
        ss_n = 1'b1;
        mosi = 1'b0;
        wait_clk(20);
    endtask

    // Reference model: decides the bus beat and the 89-bit miso image of a frame from its inputs.
    task automatic do_frame(input logic [7:0] instr, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit noack, input int delay, input logic err,
                            input logic [31:0] rdata, input int nbits);
        logic [88:0] tx, ev;
        logic [47:0] tail;
        logic [7:0]  status;
        logic [31:0] data;
        bit          is_w, is_r;
        bus_exp_t    b;
        resp_t       r;
        is_w = (instr == 8'h00);
        is_r = (instr == 8'h01);
        tail = is_w ? {wdata, 16'($urandom)} : {$urandom, 16'($urandom)};
        tx   = {instr, 1'($urandom), addr, tail};
        if (nbits == 89) begin
            ev = '0;
            if (is_w || is_r) begin
                b.we = is_w; b.addr = addr; b.wdata = wdata;
                exp_bus_q.push_back(b);
                r.noack = noack; r.delay = delay; r.err = err; r.rdata = rdata;
                resp_q.push_back(r);
                status = noack ? 8'h04 : (err ? 8'h02 : 8'h01);
                data   = (is_r && !noack && !err) ? rdata : 32'h0;
                ev     = is_r ? {49'b0, data, status} : {81'b0, status};
            end
            exp_frame_q.push_back(ev);
        end
        spi_send(tx, nbits);
    endtask

    // Bus responder
    initial begin
        logic  prev;
        resp_t r;
        int    cnt;
        prev = 1'b0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_err   = 1'b0;
        bus_if.bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus_if.bus_req && !prev) begin
                if (resp_q.size() != 0) r = resp_q.pop_front();
                else begin r.noack = 1'b1; r.delay = 0; r.err = 1'b0; r.rdata = '0; end
                if (r.noack) begin
                    cnt = 1;
                    for (int i = 0; i < 200 && bus_if.bus_req; i++) begin
                        @(negedge clk);
                        if (bus_if.bus_req) cnt++;
                    end
                    check("timeout_req_cycles", 128'(cnt), 128'(32));
                end else begin
                    repeat (r.delay) @(negedge clk);
                    check("req_held_until_ack", 128'(bus_if.bus_req), 128'(1));
                    @(posedge clk); #2;
                    bus_if.bus_ack   = 1'b1;
                    bus_if.bus_err   = r.err;
                    bus_if.bus_rdata = r.rdata;
                    @(posedge clk); #2;
                    bus_if.bus_ack   = 1'b0;
                    bus_if.bus_err   = 1'($urandom);
                    bus_if.bus_rdata = $urandom;
                    @(negedge clk);
                    check("req_drop_after_ack", 128'(bus_if.bus_req), 128'(0));
                end
            end
            prev = bus_if.bus_req;
        end
    end

    // Bus monitor
    initial begin
        logic        prev;
        bus_exp_t    e;
        logic [63:0] first_aw, last_aw;
        prev = 1'b0;
        first_aw = '0;
        last_aw = '0;
        forever begin
            @(negedge clk);
            if (bus_if.bus_req && !prev) begin
                check("bus_access_expected", 128'(exp_bus_q.size() != 0), 128'(1));
                if (exp_bus_q.size() != 0) begin
                    e = exp_bus_q.pop_front();
                    check("bus_we", 128'(bus_if.bus_we), 128'(e.we));
                    check("bus_addr", 128'(bus_if.bus_addr), 128'(e.addr));
                    if (e.we) check("bus_wdata", 128'(bus_if.bus_wdata), 128'(e.wdata));
                end
                first_aw = {bus_if.bus_addr, bus_if.bus_wdata};
            end
            if (bus_if.bus_req) last_aw = {bus_if.bus_addr, bus_if.bus_wdata};
            if (!bus_if.bus_req && prev) check("bus_addr_wdata_stable", 128'(last_aw), 128'(first_aw));
            prev = bus_if.bus_req;
        end
    end

    // Frame monitor: sniffs miso at each sck rise of a selected frame
    initial begin
        logic [88:0] vec;
        int          n;
        logic        sprev;
        forever begin
            @(negedge clk);
            if (!ss_n) begin
                vec = '0;
                n = 0;
                sprev = sck;
                while (!ss_n) begin
                    if (sck && !sprev) begin
                        vec = {vec[87:0], miso};
                        n++;
                    end
                    sprev = sck;
                    @(negedge clk);
                end
                if (n == 89) begin
                    check("frame_expected", 128'(exp_frame_q.size() != 0), 128'(1));
                    if (exp_frame_q.size() != 0) check("frame_miso", 128'(vec), 128'(exp_frame_q.pop_front()));
                end
                repeat (4) @(negedge clk);
                check("miso_idle_low", 128'(miso), 128'(0));
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int         sel;
        logic [7:0] ins;
        wait_clk(4);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_miso", 128'(miso), 128'(0));
        check("reset_bus_req", 128'(bus_if.bus_req), 128'(0));
        check("reset_bus_we", 128'(bus_if.bus_we), 128'(0));
        check("reset_bus_addr", 128'(bus_if.bus_addr), 128'(0));
        check("reset_bus_wdata", 128'(bus_if.bus_wdata), 128'(0));
        wait_clk(5);

        do_frame(8'h00, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 5, 1'b0, 32'h0, 89);
        do_frame(8'h01, 32'h0000_0024, 32'h0, 1'b0, 10, 1'b0, 32'h1234_5678, 89);
        do_frame(8'h01, $urandom, 32'h0, 1'b1, 0, 1'b0, 32'h0, 89);
        do_frame(8'h00, $urandom, $urandom, 1'b0, 3, 1'b1, 32'h0, 89);
        do_frame(8'h01, $urandom, 32'h0, 1'b0, 7, 1'b1, $urandom, 89);
        do_frame(8'h5A, $urandom, $urandom, 1'b0, 0, 1'b0, 32'h0, 89);
        do_frame(8'h01, 32'h0000_0024, 32'h0, 1'b0, 4, 1'b0, 32'hCAFE_F00D, 89);
        do_frame(8'h00, $urandom, $urandom, 1'b0, 0, 1'b0, 32'h0, 29);
        do_frame(8'h00, 32'h0000_0030, $urandom, 1'b0, 6, 1'b0, 32'h0, 89);

        for (int k = 0; k < 10; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) ins = 8'h00;
            else if (sel < 8) ins = 8'h01;
            else ins = 8'($urandom_range(2, 255));
            do_frame(ins, $urandom, $urandom, ($urandom_range(0, 7) == 0), $urandom_range(1, 20),
                     ($urandom_range(0, 3) == 0), $urandom, 89);
        end

        wait_clk(100);
        check("bus_queue_drained", 128'(exp_bus_q.size()), 128'(0));
        check("resp_queue_drained", 128'(resp_q.size()), 128'(0));
        check("frame_queue_drained", 128'(exp_frame_q.size()), 128'(0));
        check("final_bus_req", 128'(bus_if.bus_req), 128'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- SPI slave (CPOL=0, CPHA=0) that terminates the team's 89-bit register-access frame and converts it into a single-beat request on the internal register bus.
- Sits between the external SPI pins and the Goertzel core register file.
- All logic runs on the system clock. sck, ss_n and mosi are oversampled and edge-detected; sck is never used as a clock.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for sck/ss_n/mosi (>=2).
- BUS_TIMEOUT, 32, clk cycles to wait for bus_ack before declaring a timeout.
- WRITE_INSTR, 8'h00, instruction code for a write frame.
- READ_INSTR, 8'h01, instruction code for a read frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sck  in  1  SPI clock (async)
- ss_n  in  1  SPI slave select, active low (async)
- mosi  in  1  SPI data in (async)
- miso  out  1  SPI data out
- bus_req  out  1  register bus request, held until ack or timeout
- bus_we  out  1  1=write, 0=read; valid with bus_req
- bus_addr  out  32  register address
- bus_wdata  out  32  write data
- bus_ack  in  1  single-cycle completion pulse
- bus_err  in  1  error flag, qualified by bus_ack
- bus_rdata  in  32  read data, qualified by bus_ack

Behaviour:
- Reset values: miso=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0. FSM goes to IDLE; counters clear.
- Sampling:
  - sck, ss_n and mosi pass through SYNC_STAGES flops.
  - mosi is sampled on the detected sck rising edge.
  - miso is updated on the detected sck falling edge.
  - Each SPI half-period must be >= 4 clk.
- Frame, MSB first, both directions:
  - 8 instruction bits
  - 1 gap bit (ignored)
  - 32 address bits
  - Write frame: 32 data bits in, 8 dummy bits in, 8 status bits out.
  - Read frame: 8 dummy bits in, 32 data bits out, 8 status bits out.
  - Both frame types are 89 bits.
- FSM states: IDLE, INSTR, GAP, ADDR, WDATA, DUMMY, RDATA, STATUS, DONE, SKIP.
  - IDLE -> INSTR on ss_n falling.
  - INSTR -> GAP after 8 bits.
  - GAP -> ADDR after 1 bit.
  - ADDR -> WDATA (write) or DUMMY (read) after 32 bits.
  - WDATA -> DUMMY after 32 bits.
  - DUMMY -> RDATA (read) or STATUS (write) after 8 bits.
  - RDATA -> STATUS after 32 bits.
  - STATUS -> DONE after 8 bits.
  - DONE waits for ss_n high, then -> IDLE.
  - An instruction other than WRITE_INSTR/READ_INSTR -> SKIP: no bus access, miso=0 until ss_n high.
- Bus issue:
  - Read: bus_req rises on the clk after the 32nd address bit is sampled.
  - Write: bus_req rises on the clk after the 32nd data bit is sampled.
  - bus_addr/bus_wdata are stable while bus_req=1.
  - bus_req drops on the cycle after bus_ack, or after BUS_TIMEOUT cycles without ack.
  - On ack: rdata and err are captured.
- Status byte = {5'b0, timeout, err, ok}.
  - ok = acked and !bus_err.
  - Read with err or timeout: data shifted out is 32'h0.
- miso drive:
  - The first read-data bit is driven on the sck falling edge following the last dummy rising edge.
  - The first status bit is driven on the falling edge following the last data bit (read) or last dummy bit (write).
  - Otherwise miso=0, including whenever ss_n=1.
- ss_n rising mid-frame:
  - FSM -> IDLE immediately; miso=0.
  - An in-flight bus_req completes normally (ack or timeout) and its result is discarded.
  - A frame aborted before bus issue produces no bus access.
- ss_n falling while a discarded bus access is still pending: the new frame proceeds. Its own bus access waits until bus_req has dropped.
- Extra sck edges in DONE are ignored.
- Reset mid-frame: all state cleared asynchronously; the bus request is dropped.

Decomposition:
- Package spi_reg_pkg holds:
  - FSM state enum
  - instruction constants
  - field lengths: INSTR_BITS=8, GAP_BITS=1, ADDR_BITS=32, DATA_BITS=32, DUMMY_BITS=8, STATUS_BITS=8
  - status bit indices
- Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall detect for sck, and level sync for ss_n/mosi.

Test Plan:
- Write 0xDEADBEEF to addr 0x00000010:
  - one bus write with addr=0x10, wdata=0xDEADBEEF
  - bench acks after 5 clk with err=0 -> status=0x01.
- Read addr 0x00000024, bench returns 0x12345678 after 10 clk -> master reads data=0x12345678, status=0x01.
- Read with bus_ack never asserted -> bus_req drops after 32 clk; data=0x00000000, status=0x04.
- Write acked with bus_err=1 -> status=0x02; read acked with bus_err=1 -> data=0, status=0x02.
- Instruction 0x5A, then a full frame -> no bus_req, miso=0 throughout; a following valid read of 0x24 succeeds.
- ss_n raised after 20 address bits, then a full write to 0x30 -> exactly one bus access (the write to 0x30), status=0x01.
